// File: rtl/pwm_cmd_sched.sv
// Command scheduler between the UART packet receiver and the PWM channel bank.
// Queues packets, holds shadow/active channel config, sequences start/stop.
module pwm_cmd_sched #(
    parameter int _CH_NUM    = 8,
    parameter int _PAT_WIDTH = 16,
    parameter int _QDEPTH    = 4,
    parameter int _STOP_TMO  = 1024,
    parameter int _IDLE_CYC  = 50000
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           recv_done,
    input  logic [7:0]                     dataA,
    input  logic [15:0]                    dataB,
    input  logic [15:0]                    dataC,
    input  logic [7:0]                     dataD,
    input  logic [_CH_NUM-1:0]             pwm_busy,
    input  logic [_CH_NUM-1:0]             pwm_valid,
    output logic [_CH_NUM-1:0]             pwm_en,
    output logic [8*_CH_NUM-1:0]           duty_num,
    output logic [16*_CH_NUM-1:0]          pulse_dessert,
    output logic [8*_CH_NUM-1:0]           pulse_num,
    output logic [_PAT_WIDTH*_CH_NUM-1:0]  pat,
    output logic                           cmd_ack,
    output logic                           cmd_err,
    output logic                           q_ovf,
    output logic                           sleep_req
);

    localparam int QAW = $clog2(_QDEPTH);
    localparam int TW  = $clog2(_STOP_TMO + 1);
    localparam int ICW = $clog2(_IDLE_CYC + 1);

    localparam logic [QAW-1:0] PTR_ONE = 1;
    localparam logic [QAW:0]   CNT_ONE = 1;
    localparam logic [QAW:0]   CNT_FULL = (QAW+1)'(_QDEPTH);
    localparam logic [TW-1:0]  TMO_ONE = 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(_STOP_TMO - 1);
    localparam logic [ICW-1:0] IDLE_ONE = 1;
    localparam logic [ICW-1:0] IDLE_SAT = ICW'(_IDLE_CYC);

    localparam int OP_NOP      = 0;
    localparam int OP_LOAD     = 1;
    localparam int OP_SETNUM   = 2;
    localparam int OP_START    = 3;
    localparam int OP_STOP     = 4;
    localparam int OP_STARTALL = 5;
    localparam int OP_STOPALL  = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_APPLY,
        S_WAIT
    } state_t;

    state_t r_state;

    // Queue entry: {op, ch, dataB, dataC, dataD}; reserved bits are not stored.
    logic [45:0]    r_qmem [_QDEPTH];
    logic [QAW-1:0] r_wp;
    logic [QAW-1:0] r_rp;
    logic [QAW:0]   r_cnt;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic [45:0]    w_head;

    logic [2:0]  r_op;
    logic [2:0]  r_ch;
    logic [15:0] r_b;
    logic [15:0] r_c;
    logic [7:0]  r_d;

    logic [7:0]            r_sh_duty [_CH_NUM];
    logic [15:0]           r_sh_dess [_CH_NUM];
    logic [7:0]            r_sh_pnum [_CH_NUM];
    logic [_PAT_WIDTH-1:0] r_sh_pat  [_CH_NUM];

    logic [8*_CH_NUM-1:0]          r_duty;
    logic [16*_CH_NUM-1:0]         r_dess;
    logic [8*_CH_NUM-1:0]          r_pnum;
    logic [_PAT_WIDTH*_CH_NUM-1:0] r_pat;

    logic [_CH_NUM-1:0] r_en;
    logic [_CH_NUM-1:0] r_set;
    logic [TW-1:0]      r_tmo;
    logic [ICW-1:0]     r_idle;
    logic               r_ack;
    logic               r_err;
    logic               r_ovf;

    logic [7:0]         w_op;
    logic [_CH_NUM-1:0] w_ch_oh;
    logic               w_ch_ok;
    logic [_CH_NUM-1:0] w_start_set;
    logic               w_start_bad;
    logic [_CH_NUM-1:0] w_en_clr;
    logic [_CH_NUM-1:0] w_en_set;
    logic [_CH_NUM-1:0] w_retire;
    logic               w_all_idle;
    logic               w_busy_ch;
    logic               w_unused;

    assign w_full  = (r_cnt == CNT_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_push  = recv_done & ~w_full;
    assign w_pop   = (r_state == S_IDLE) & ~w_empty;
    assign w_head  = r_qmem[r_rp];

    assign w_op       = 8'b1 << r_op;
    assign w_ch_ok    = |w_ch_oh;
    assign w_busy_ch  = |(pwm_busy & w_ch_oh);
    assign w_all_idle = ~(|r_en) & ~(|pwm_busy);
    assign w_unused   = ^{dataA[4:3], r_c};

    always_comb begin
        w_ch_oh  = '0;
        w_retire = '0;
        for (int i = 0; i < _CH_NUM; i++) begin
            w_ch_oh[i]  = (r_ch == 3'(i));
            w_retire[i] = pwm_valid[i] & r_en[i] & (r_sh_pnum[i] != 8'd0);
        end
    end

    always_comb begin
        w_start_set = w_op[OP_STARTALL] ? r_d[_CH_NUM-1:0] : w_ch_oh;
        w_start_bad = (w_op[OP_START] & ~w_ch_ok) | (|(w_start_set & r_en));
        w_en_clr    = '0;
        w_en_set    = '0;
        if (r_state == S_EXEC && w_op[OP_STOP])
            w_en_clr = w_ch_oh;
        if (r_state == S_EXEC && w_op[OP_STOPALL])
            w_en_clr = '1;
        if (r_state == S_APPLY)
            w_en_set = r_set;
    end

    always_ff @(posedge sys_clk) begin
        if (w_push)
            r_qmem[r_wp] <= {dataA[7:5], dataA[2:0], dataB, dataC, dataD};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_ch      <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_sh_duty <= '{default: '0};
            r_sh_dess <= '{default: '0};
            r_sh_pnum <= '{default: '0};
            r_sh_pat  <= '{default: '0};
            r_duty    <= '0;
            r_dess    <= '0;
            r_pnum    <= '0;
            r_pat     <= '0;
            r_en      <= '0;
            r_set     <= '0;
            r_tmo     <= '0;
            r_idle    <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            // Retire wins over everything so a finished burst never stays enabled.
            r_en  <= ((r_en & ~w_en_clr) | w_en_set) & ~w_retire;

            if (w_push)
                r_wp <= r_wp + PTR_ONE;
            if (w_pop)
                r_rp <= r_rp + PTR_ONE;
            if (w_push & ~w_pop)
                r_cnt <= r_cnt + CNT_ONE;
            else if (~w_push & w_pop)
                r_cnt <= r_cnt - CNT_ONE;
            if (recv_done & w_full)
                r_ovf <= 1'b1;

            if (!w_all_idle)
                r_idle <= '0;
            else if (r_idle != IDLE_SAT)
                r_idle <= r_idle + IDLE_ONE;

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_op    <= w_head[45:43];
                        r_ch    <= w_head[42:40];
                        r_b     <= w_head[39:24];
                        r_c     <= w_head[23:8];
                        r_d     <= w_head[7:0];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    unique case (1'b1)
                        w_op[OP_NOP]: r_ack <= 1'b1;
                        w_op[OP_LOAD]: begin
                            r_ack <= w_ch_ok;
                            r_err <= ~w_ch_ok;
                            for (int i = 0; i < _CH_NUM; i++) begin
                                if (w_ch_oh[i]) begin
                                    r_sh_duty[i] <= r_d;
                                    r_sh_dess[i] <= r_b;
                                    r_sh_pat[i]  <= r_c[_PAT_WIDTH-1:0];
                                end
                            end
                        end
                        w_op[OP_SETNUM]: begin
                            r_ack <= w_ch_ok;
                            r_err <= ~w_ch_ok;
                            for (int i = 0; i < _CH_NUM; i++)
                                if (w_ch_oh[i])
                                    r_sh_pnum[i] <= r_d;
                        end
                        w_op[OP_START], w_op[OP_STARTALL]: begin
                            if (w_start_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                for (int i = 0; i < _CH_NUM; i++) begin
                                    if (w_start_set[i]) begin
                                        r_duty[8*i +: 8]  <= r_sh_duty[i];
                                        r_dess[16*i +: 16] <= r_sh_dess[i];
                                        r_pnum[8*i +: 8]  <= r_sh_pnum[i];
                                        r_pat[_PAT_WIDTH*i +: _PAT_WIDTH] <= r_sh_pat[i];
                                    end
                                end
                                r_set   <= w_start_set;
                                r_state <= S_APPLY;
                            end
                        end
                        w_op[OP_STOP]: begin
                            if (w_ch_ok) begin
                                r_tmo   <= '0;
                                r_state <= S_WAIT;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        w_op[OP_STOPALL]: r_ack <= 1'b1;
                        default: r_err <= 1'b1;
                    endcase
                end
                S_APPLY: begin
                    r_ack   <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_WAIT: begin
                    if (!w_busy_ch) begin
                        r_ack   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
                end
            endcase
        end
    end

    assign pwm_en        = r_en;
    assign duty_num      = r_duty;
    assign pulse_dessert = r_dess;
    assign pulse_num     = r_pnum;
    assign pat           = r_pat;
    assign cmd_ack       = r_ack;
    assign cmd_err       = r_err;
    assign q_ovf         = r_ovf;
    assign sleep_req     = (r_idle == IDLE_SAT);

endmodule
